// File: rtl/aes_key_schedule_engine_if.sv
// Request, status, S-Box memory and round-key read bundle of the AES key-schedule engine.
interface aes_key_schedule_engine_if #(
    parameter int ADDR_W = 12
);
    logic              start;
    logic [1:0]        key_mode;
    logic [255:0]      key_in;
    logic              busy;
    logic              done;
    logic              err;
    logic              keys_valid;
    logic [3:0]        num_rounds;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic [3:0]        rk_idx;
    logic [127:0]      rk_data;

    modport master (
        output start, key_mode, key_in, mem_rdata, rk_idx,
        input  busy, done, err, keys_valid, num_rounds, mem_en, mem_addr, rk_data
    );

    modport slave (
        input  start, key_mode, key_in, mem_rdata, rk_idx,
        output busy, done, err, keys_valid, num_rounds, mem_en, mem_addr, rk_data
    );
endinterface

// File: rtl/aes_key_schedule_engine.sv
// Iterative AES-128/192/256 key expansion: one schedule word per step, S-Box bytes
// fetched serially from unified memory, round keys read combinationally.
module aes_key_schedule_engine #(
    parameter int ADDR_W    = 12,
    parameter int SBOX_BASE = 0,
    parameter int MAX_WORDS = 60
) (
    input logic                      clk,
    input logic                      rst,
    aes_key_schedule_engine_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_EXPAND = 3'd2;
    localparam logic [2:0] S_SUB    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(SBOX_BASE);

    logic [2:0]   state;
    logic [31:0]  w [MAX_WORDS];
    logic [255:0] key_q;
    logic [3:0]   nk;
    logic [5:0]   i;
    logic [2:0]   j;          // i mod Nk, kept as a counter to avoid a divider
    logic [2:0]   sub_cnt;
    logic [7:0]   rcon;
    logic [31:0]  sub_src;
    logic [31:0]  sub_word;

    logic [5:0]   end_i, rk_base;
    logic         rcon_path, sub_path, nxt_sub;
    logic [2:0]   j_nxt;
    logic [31:0]  new_word, key_last;

    function automatic logic [31:0] rot_word(input logic [31:0] x);
        return {x[23:0], x[31:24]};
    endfunction

    always_comb begin
        end_i     = {bus.num_rounds, 2'b00} + 6'd4;
        rcon_path = (j == 3'd0);
        sub_path  = rcon_path || (nk == 4'd8 && j == 3'd4);
        new_word  = w[i - {2'b00, nk}] ^
                    (sub_path ? (sub_word ^ {(rcon_path ? rcon : 8'h00), 24'h0}) : w[i - 6'd1]);
        j_nxt     = ({1'b0, j} == nk - 4'd1) ? 3'd0 : j + 3'd1;
        nxt_sub   = (j_nxt == 3'd0) || (nk == 4'd8 && j_nxt == 3'd4);
        case (nk)
            4'd4:    key_last = key_q[159:128];
            4'd6:    key_last = key_q[95:64];
            default: key_last = key_q[31:0];
        endcase
    end

    always_comb begin
        rk_base     = {bus.rk_idx, 2'b00};
        bus.rk_data = '0;
        if (bus.keys_valid && bus.rk_idx <= bus.num_rounds)
            bus.rk_data = {w[rk_base], w[rk_base + 6'd1], w[rk_base + 6'd2], w[rk_base + 6'd3]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
            bus.keys_valid <= 1'b0;
            bus.num_rounds <= 4'd0;
            bus.mem_en     <= 1'b0;
            bus.mem_addr   <= '0;
            for (int k = 0; k < MAX_WORDS; k++) w[k] <= 32'h0;
            key_q    <= '0;
            nk       <= 4'd4;
            i        <= 6'd0;
            j        <= 3'd0;
            sub_cnt  <= 3'd0;
            rcon     <= 8'h00;
            sub_src  <= 32'h0;
            sub_word <= 32'h0;
        end else begin
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.key_mode == 2'd3) begin
                            bus.err <= 1'b1;
                        end else begin
                            nk             <= 4'd4 + {1'b0, bus.key_mode, 1'b0};
                            bus.num_rounds <= 4'd10 + {1'b0, bus.key_mode, 1'b0};
                            key_q          <= bus.key_in;
                            bus.busy       <= 1'b1;
                            bus.keys_valid <= 1'b0;
                            state          <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    // Words past Nk-1 get key filler here but are rewritten by the expansion.
                    for (int k = 0; k < 8; k++) w[k] <= key_q[255-32*k -: 32];
                    i            <= {2'b00, nk};
                    j            <= 3'd0;
                    rcon         <= 8'h01;
                    sub_src      <= rot_word(key_last);
                    bus.mem_en   <= 1'b1;
                    bus.mem_addr <= BASE + ADDR_W'(key_last[23:16]);
                    sub_cnt      <= 3'd0;
                    state        <= S_SUB;
                end
                S_SUB: begin
                    // Byte k is issued in cycle k and returns in cycle k+1, MSB first.
                    if (sub_cnt != 3'd0) sub_word <= {sub_word[23:0], bus.mem_rdata};
                    if (sub_cnt < 3'd3) begin
                        bus.mem_en   <= 1'b1;
                        bus.mem_addr <= BASE + ADDR_W'(sub_src[23:16]);
                        sub_src      <= sub_src << 8;
                    end else begin
                        bus.mem_en <= 1'b0;
                    end
                    if (sub_cnt == 3'd4) state <= S_EXPAND;
                    else                 sub_cnt <= sub_cnt + 3'd1;
                end
                S_EXPAND: begin
                    w[i] <= new_word;
                    i    <= i + 6'd1;
                    j    <= j_nxt;
                    if (rcon_path) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                    // The next word's path is decided here so an S-Box word costs only SUB + one write cycle.
                    if (i + 6'd1 == end_i) begin
                        bus.done       <= 1'b1;
                        bus.busy       <= 1'b0;
                        bus.keys_valid <= 1'b1;
                        state          <= S_DONE;
                    end else if (nxt_sub) begin
                        sub_cnt    <= 3'd0;
                        bus.mem_en <= 1'b1;
                        state      <= S_SUB;
                        if (j_nxt == 3'd0) begin
                            sub_src      <= rot_word(new_word);
                            bus.mem_addr <= BASE + ADDR_W'(new_word[23:16]);
                        end else begin
                            sub_src      <= new_word;
                            bus.mem_addr <= BASE + ADDR_W'(new_word[31:24]);
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_key_schedule_engine.sv
// Self-checking bench: FIPS-197 vectors plus random keys against an in-bench key-expansion model.
module tb_aes_key_schedule_engine;
    localparam int ADDR_W    = 12;
    localparam int SBOX_BASE = 'h2a5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_key_schedule_engine_if #(.ADDR_W(ADDR_W)) bus ();

    aes_key_schedule_engine #(
        .ADDR_W(ADDR_W), .SBOX_BASE(SBOX_BASE), .MAX_WORDS(60)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    logic [7:0]  sbox [256];
    logic [31:0] ref_w [60];
    int          ref_subs;
    int          tests = 0;
    int          fails = 0;

    // S-Box ROM with one cycle of read latency; idle cycles return noise.
    always @(posedge clk) begin
        if (bus.mem_en) bus.mem_rdata <= sbox[8'(bus.mem_addr - ADDR_W'(SBOX_BASE))];
        else            bus.mem_rdata <= 8'($urandom);
    end

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int n = 0; n < 8; n++) begin
            if (b[n]) p ^= a;
            a = xt(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] b;
        b = 8'h00;
        if (x != 8'h00) begin
            b = 8'h01;
            for (int e = 0; e < 254; e++) b = gmul(b, x);
        end
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
    endfunction

    function automatic int lat_exp(input int mode);
        return (mode == 0) ? 91 : (mode == 1) ? 87 : 118;
    endfunction

    task automatic build_ref(input int mode, input logic [255:0] key);
        int nk, total;
        logic [31:0] t;
        logic [7:0] rc;
        nk = 4 + 2 * mode;
        total = 4 * (nk + 7);
        rc = 8'h01;
        ref_subs = 0;
        for (int k = 0; k < nk; k++) ref_w[k] = key[255-32*k -: 32];
        for (int k = nk; k < total; k++) begin
            t = ref_w[k-1];
            if (k % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
                ref_subs++;
            end else if (nk == 8 && k % 8 == 4) begin
                t = subw(t);
                ref_subs++;
            end
            ref_w[k] = ref_w[k-nk] ^ t;
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_key(output logic [255:0] k);
        for (int b = 0; b < 8; b++) k[32*b +: 32] = $urandom();
    endtask

    // One full expansion; optionally re-pulses start with a different key mid-run.
    task automatic run(input int mode, input logic [255:0] key, input bit repulse,
                       output int lat, output int ens);
        bit got;
        int nr;
        got = 1'b0;
        lat = 0;
        ens = 0;
        nr  = 10 + 2 * mode;
        build_ref(mode, key);
        @(negedge clk);
        bus.start = 1'b1; bus.key_mode = 2'(mode); bus.key_in = key;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("busy_after_accept", 128'(bus.busy), 128'd1);
        chk("kv_cleared", 128'(bus.keys_valid), 128'd0);
        while (!got && lat < 400) begin
            @(posedge clk); #1;
            lat++;
            if (bus.mem_en) ens++;
            if (bus.done) got = 1'b1;
            if (repulse) begin
                bus.start    = (lat == 30);
                bus.key_in   = ~key;
                bus.key_mode = 2'((mode + 1) % 3);
            end
        end
        bus.start = 1'b0;
        chk("done_seen", 128'(got), 128'd1);
        @(posedge clk); #1;
        chk("done_one_cycle", 128'(bus.done), 128'd0);
        chk("busy_idle", 128'(bus.busy), 128'd0);
        chk("kv_set", 128'(bus.keys_valid), 128'd1);
        chk("num_rounds", 128'(bus.num_rounds), 128'(nr));
        chk("mem_en_count", 128'(ens), 128'(4 * ref_subs));
        for (int r = 0; r <= nr; r++) begin
            bus.rk_idx = 4'(r); #1;
            chk($sformatf("rk%0d_m%0d", r, mode), bus.rk_data,
                {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]});
        end
        bus.rk_idx = 4'(nr + 1); #1;
        chk("rk_beyond_nr", bus.rk_data, 128'd0);
    endtask

    initial begin
        int lat, ens, n;
        logic [255:0] k;
        for (int x = 0; x < 256; x++) sbox[x] = sbox_calc(8'(x));
        bus.start = 1'b0; bus.key_mode = 2'd0; bus.key_in = '0; bus.rk_idx = 4'd0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 128'(bus.busy), 128'd0);
        chk("rst_done", 128'(bus.done), 128'd0);
        chk("rst_err", 128'(bus.err), 128'd0);
        chk("rst_kv", 128'(bus.keys_valid), 128'd0);
        chk("rst_mem_en", 128'(bus.mem_en), 128'd0);
        chk("rst_mem_addr", 128'(bus.mem_addr), 128'd0);
        chk("rst_num_rounds", 128'(bus.num_rounds), 128'd0);
        chk("rst_rk_data", bus.rk_data, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        k = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        run(0, k, 1'b0, lat, ens);
        chk("aes128_latency", 128'(lat), 128'd91);
        bus.rk_idx = 4'd1; #1;
        chk("fips128_rk1", bus.rk_data, 128'ha0fafe1788542cb123a339392a6c7605);
        bus.rk_idx = 4'd10; #1;
        chk("fips128_rk10", bus.rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        k = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
        run(1, k, 1'b0, lat, ens);
        chk("aes192_latency", 128'(lat), 128'd87);
        bus.rk_idx = 4'd12; #1;
        chk("fips192_rk12", bus.rk_data, 128'ha4970a331a78dc09c418c271e3a41d5d);
        bus.rk_idx = 4'd13; #1;
        chk("fips192_rk13", bus.rk_data, 128'd0);

        k = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        run(2, k, 1'b0, lat, ens);
        chk("aes256_latency", 128'(lat), 128'd118);
        chk("aes256_mem_en", 128'(ens), 128'd52);
        bus.rk_idx = 4'd14; #1;
        chk("fips256_rk14", bus.rk_data, 128'h24fc79ccbf0979e9371ac23c6d68de36);

        // Illegal mode: err pulse only, previous schedule stays valid.
        @(negedge clk);
        bus.start = 1'b1; bus.key_mode = 2'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("illegal_err", 128'(bus.err), 128'd1);
        chk("illegal_busy", 128'(bus.busy), 128'd0);
        @(posedge clk); #1;
        chk("illegal_err_pulse", 128'(bus.err), 128'd0);
        ens = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus.mem_en) ens++;
        end
        chk("illegal_no_mem", 128'(ens), 128'd0);
        chk("illegal_busy_after", 128'(bus.busy), 128'd0);
        chk("illegal_kv", 128'(bus.keys_valid), 128'd1);

        for (int r = 0; r < 6; r++) begin
            rand_key(k);
            run(r % 3, k, r >= 3, lat, ens);
            chk($sformatf("rand_latency_%0d", r), 128'(lat), 128'(lat_exp(r % 3)));
        end

        // Reset in the middle of a SUB step, then a clean AES-128 run.
        rand_key(k);
        @(negedge clk);
        bus.start = 1'b1; bus.key_mode = 2'd0; bus.key_in = k;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        while (!bus.mem_en && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("sub_reached", 128'(bus.mem_en), 128'd1);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 128'(bus.busy), 128'd0);
        chk("midrst_mem_en", 128'(bus.mem_en), 128'd0);
        chk("midrst_mem_addr", 128'(bus.mem_addr), 128'd0);
        chk("midrst_kv", 128'(bus.keys_valid), 128'd0);
        chk("midrst_num_rounds", 128'(bus.num_rounds), 128'd0);
        chk("midrst_rk_data", bus.rk_data, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        rand_key(k);
        run(0, k, 1'b0, lat, ens);
        chk("post_rst_latency", 128'(lat), 128'd91);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/aes_key_schedule_engine.md
Name: aes_key_schedule_engine

Overview:
- Iterative AES key-expansion engine for AES-128/192/256, selected at run time by key_mode.
- Computes one 32-bit schedule word per step and fetches S-Box bytes from the unified memory, byte by byte, through a read port with 1-cycle latency.
- Rcon is generated internally.
- Stores up to 60 words and presents any round key on a combinational read port to the execute-stage cipher rounds.

Parameters:
- ADDR_W, 12, unified-memory address width.
- SBOX_BASE, 0, unified-memory address of S-Box entry 0x00.
- MAX_WORDS, 60, schedule storage depth in 32-bit words. Fixed for AES-256 and must be ≥ 60.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  expansion request, sampled in IDLE only
- key_mode  in  2  0=AES-128, 1=AES-192, 2=AES-256, 3=illegal
- key_in  in  256  cipher key, left-aligned: w[0]=key_in[255:224]; AES-128 uses [255:128], AES-192 uses [255:64]
- busy  out  1  expansion in progress
- done  out  1  one-cycle pulse when expansion completes
- err  out  1  one-cycle pulse when start is rejected for key_mode=3
- keys_valid  out  1  schedule complete and readable
- num_rounds  out  4  Nr of the latched mode (10/12/14)
- mem_en  out  1  S-Box read strobe
- mem_addr  out  ADDR_W  SBOX_BASE + byte
- mem_rdata  in  8  S-Box byte, valid the cycle after mem_en
- rk_idx  in  4  round-key select
- rk_data  out  128  {w[4r],w[4r+1],w[4r+2],w[4r+3]}, w[4r] in [127:96]

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - busy, done, err, keys_valid and mem_en = 0.
  - mem_addr = 0, num_rounds = 0.
  - Word array cleared to 0.
- rk_data:
  - Combinational from the array.
  - Equals 0 when keys_valid=0 or rk_idx > num_rounds.
- Start acceptance in IDLE with start=1:
  - key_mode=3: err=1 for one cycle, state unchanged.
  - Otherwise, on that edge: latch Nk (4/6/8) and Nr (10/12/14), busy=1, keys_valid=0.
- start while busy: ignored. key_in and key_mode are sampled only at acceptance.
- FSM states: IDLE → LOAD → EXPAND ↔ SUB → DONE → IDLE.
- LOAD (1 cycle):
  - Write w[0..Nk-1] from the latched key.
  - Set i=Nk and rcon=0x01.
- EXPAND, with temp=w[i-1]:
  - If i mod Nk == 0: go to SUB on RotWord(temp)={t1,t2,t3,t0}, using Rcon.
  - Else if Nk==8 and i mod 8 == 4: go to SUB on temp, without Rcon.
  - Otherwise: write w[i]=w[i-Nk]^temp in this cycle and increment i.
  - When i == 4*(Nr+1), go to DONE instead.
- SUB (5 cycles, then return to EXPAND):
  - Cycles 0–3: mem_en=1, mem_addr=SBOX_BASE+byte k, MSB byte first.
  - Cycles 1–4: capture mem_rdata.
  - Back in EXPAND (1 cycle): write w[i]=w[i-Nk]^SubWord, XOR-ing {rcon,24'h0} only on the Rcon path.
  - After the Rcon path: rcon=xtime(rcon), i.e. shift left 1 and XOR 0x1B if bit7 was set.
  - Each S-Box word costs 6 cycles; each plain word costs 1 cycle.
- DONE (1 cycle): done=1, busy=0, keys_valid=1, then return to IDLE.
- Latency from the acceptance edge to the done-high cycle: AES-128 = 91, AES-192 = 87, AES-256 = 118 cycles.
- keys_valid stays high until the next accepted start or reset.
- mem_en=0 outside SUB cycles 0–3. mem_addr holds its last value.
- Reset mid-SUB: in-flight memory data is discarded and no stale word is written.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, 1-cycle S-Box ROM model:
  - rk_idx=1 → a0fafe1788542cb123a339392a6c7605.
  - rk_idx=10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done exactly 91 cycles after acceptance.
- AES-192, key 000102…17:
  - rk_idx=12 → a4970a331a78dc09c418c271e3a41d5d.
  - num_rounds=12, done at 87 cycles.
  - rk_idx=13 → 0.
- AES-256, key 000102…1f:
  - rk_idx=14 → 24fc79ccbf0979e9371ac23c6d68de36.
  - done at 118 cycles.
  - Exactly 52 mem_en cycles observed (13 SubWords).
- key_mode=3 with start:
  - err pulses for 1 cycle.
  - busy stays 0, keys_valid unchanged, no mem_en.
- start re-pulsed mid-expansion, and key_in changed: ignored; result still matches the original key.
- rst asserted during a SUB cycle:
  - Outputs go to 0 immediately.
  - After release, a new AES-128 start produces the correct schedule.
